// File: rtl/netlist_eval_pkg.sv
// netlist_eval_pkg: opcodes, FSM states and the gate-record layout shared by the evaluator
package netlist_eval_pkg;
    localparam int ID_W = 4;
    typedef enum logic [2:0] {
        OP_VCC, OP_GND, OP_BUF, OP_NOT, OP_AND2, OP_OR2, OP_XOR2, OP_NOP
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_EVAL} state_e;
    typedef struct packed {
        op_e             op;
        logic [ID_W-1:0] in0;
        logic [ID_W-1:0] in1;
        logic [ID_W-1:0] out;
        logic            last;
    } rec_t;
endpackage

// File: rtl/netlist_eval_gate_alu.sv
// gate_alu: combinational evaluation of one netlist primitive
module gate_alu
    import netlist_eval_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic y
);
    // primitive truth function; NOP yields 0 and is never written back
    always_comb begin
        y = op == OP_VCC  ? 1'b1 :
            op == OP_GND  ? 1'b0 :
            op == OP_BUF  ? a :
            op == OP_NOT  ? ~a :
            op == OP_AND2 ? a & b :
            op == OP_OR2  ? a | b :
            op == OP_XOR2 ? a ^ b : 1'b0;
    end
endmodule

// File: rtl/netlist_eval.sv
// netlist_eval: streams gate records and evaluates them in order against a flat net file
module netlist_eval
    import netlist_eval_pkg::*;
#(
    parameter int NET_W = ID_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [2:0]       rec_op,
    input  logic [NET_W-1:0] rec_in0,
    input  logic [NET_W-1:0] rec_in1,
    input  logic [NET_W-1:0] rec_out,
    input  logic             rec_last,
    input  logic             inp_we,
    input  logic [NET_W-1:0] inp_addr,
    input  logic             inp_data,
    input  logic [NET_W-1:0] rd_addr,
    output logic             rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] gate_cnt
);
    state_e               state_q, state_d;
    rec_t                 rec_q;
    logic [2**NET_W-1:0]  net_q;
    logic                 accept;
    logic                 y;

    gate_alu u_alu (
        .op(rec_q.op),
        .a (net_q[NET_W'(rec_q.in0)]),
        .b (net_q[NET_W'(rec_q.in1)]),
        .y (y)
    );

    assign rd_data = net_q[rd_addr];

    // handshake, busy window and next state; ready depends only on state
    always_comb begin
        rec_ready = state_q != S_EVAL;
        accept    = rec_ready & rec_valid;
        busy      = state_q != S_IDLE || accept;
        state_d   = accept ? S_EVAL :
                    state_q == S_EVAL ? (rec_q.last ? S_IDLE : S_CAPT) : state_q;
    end

    // state, record latch, net-file writes, counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rec_q    <= '0;
            net_q    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            gate_cnt <= '0;
        end else begin
            state_q <= state_d;
            done    <= state_q == S_EVAL && rec_q.last;
            if (accept)
                rec_q <= '{op: op_e'(rec_op), in0: ID_W'(rec_in0), in1: ID_W'(rec_in1),
                           out: ID_W'(rec_out), last: rec_last};
            if (state_q == S_EVAL && rec_q.op != OP_NOP) begin
                net_q[NET_W'(rec_q.out)] <= y;
                gate_cnt <= gate_cnt + CNT_W'(gate_cnt != '1);
            end
            if (inp_we && busy)
                err <= 1'b1;
            else if (inp_we)
                net_q[inp_addr] <= inp_data;
        end
    end
endmodule

// File: tb/tb_netlist_eval.sv
// tb_netlist_eval: directed gate streams with hand-computed net values
module tb_netlist_eval;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rec_valid = 1'b0;
    logic       rec_ready;
    logic [2:0] rec_op = '0;
    logic [3:0] rec_in0 = '0;
    logic [3:0] rec_in1 = '0;
    logic [3:0] rec_out = '0;
    logic       rec_last = 1'b0;
    logic       inp_we = 1'b0;
    logic [3:0] inp_addr = '0;
    logic       inp_data = 1'b0;
    logic [3:0] rd_addr = '0;
    logic       rd_data, busy, done, err;
    logic [7:0] gate_cnt;
    logic [15:0] nets;
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int c0 = 0;

    netlist_eval #(.NET_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_op(rec_op), .rec_in0(rec_in0), .rec_in1(rec_in1), .rec_out(rec_out),
        .rec_last(rec_last), .inp_we(inp_we), .inp_addr(inp_addr), .inp_data(inp_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .gate_cnt(gate_cnt)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic d);
        inp_we = 1'b1; inp_addr = a; inp_data = d;
        @(posedge clk);
        #1 inp_we = 1'b0;
    endtask

    task automatic read_nets(output logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1 v[i] = rd_data;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] o, input logic l, input logic first);
        int t = 0;
        rec_valid = 1'b1; rec_op = op; rec_in0 = a; rec_in1 = b; rec_out = o; rec_last = l;
        while (!rec_ready && t < 10) begin
            @(posedge clk);
            #1 t++;
        end
        if (t == 10) check("ready_timeout", 0, 1);
        if (first) c0 = cyc;
        @(posedge clk);
        #1 rec_valid = 1'b0;
        rec_last = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int t = 0;
        while (!done && t < 20) begin
            @(posedge clk);
            #1 t++;
        end
        check("done_seen", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        if (exp_cyc > 0) check("done_cycle", 32'(cyc - c0), 32'(exp_cyc));
    endtask

    task automatic and_stream();
        send(3'd4, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
        send(3'd2, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0);
        send(3'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        send(3'd4, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
    endtask

    initial begin
        do_reset();
        check("rst_ready", 32'(rec_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", 32'(gate_cnt), 0);
        read_nets(nets);
        check("rst_nets", 32'(nets), 0);

        host_write(4'd1, 1'b1);
        host_write(4'd2, 1'b1);
        and_stream();
        wait_done(8);
        read_nets(nets);
        check("and1_nets", 32'(nets), 32'h007E);
        check("and1_cnt", 32'(gate_cnt), 4);
        @(posedge clk);
        #1 check("done_pulse_end", 32'(done), 0);

        do_reset();
        host_write(4'd1, 1'b1);
        and_stream();
        wait_done(8);
        read_nets(nets);
        check("and0_nets", 32'(nets), 32'h0022);
        check("and0_cnt", 32'(gate_cnt), 4);

        do_reset();
        host_write(4'd3, 1'b1);
        send(3'd4, 4'd3, 4'd5, 4'd3, 1'b0, 1'b1);
        @(posedge clk);
        #1 check("inplace_cnt", 32'(gate_cnt), 1);
        send(3'd7, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        wait_done(4);
        read_nets(nets);
        check("inplace_nets", 32'(nets), 0);
        check("nop_cnt", 32'(gate_cnt), 1);

        do_reset();
        host_write(4'd7, 1'b1);
        send(3'd0, 4'd0, 4'd0, 4'd8, 1'b0, 1'b1);
        inp_we = 1'b1; inp_addr = 4'd7; inp_data = 1'b0;
        @(posedge clk);
        #1 inp_we = 1'b0;
        check("err_set", 32'(err), 1);
        send(3'd2, 4'd8, 4'd0, 4'd9, 1'b0, 1'b0);
        send(3'd3, 4'd9, 4'd0, 4'd10, 1'b1, 1'b0);
        wait_done(6);
        read_nets(nets);
        check("err_nets", 32'(nets), 32'h0380);
        check("err_cnt", 32'(gate_cnt), 3);
        host_write(4'd7, 1'b0);
        check("err_sticky", 32'(err), 1);
        rd_addr = 4'd7;
        #1 check("idle_write", 32'(rd_data), 0);
        do_reset();
        check("err_cleared", 32'(err), 0);

        host_write(4'd1, 1'b1);
        send(3'd2, 4'd1, 4'd0, 4'd2, 1'b0, 1'b1);
        send(3'd2, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0);
        do_reset();
        check("abort_ready", 32'(rec_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_cnt", 32'(gate_cnt), 0);
        read_nets(nets);
        check("abort_nets", 32'(nets), 0);
        @(posedge clk);
        #1 check("abort_no_done", 32'(done), 0);

        for (int i = 0; i < 260; i++)
            send(3'd0, 4'd0, 4'd0, 4'd9, 1'(i == 259), 1'(i == 0));
        wait_done(520);
        check("sat_cnt", 32'(gate_cnt), 255);
        rd_addr = 4'd9;
        #1 check("sat_net", 32'(rd_data), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
